// File: rtl/rs_enc_scheduler.sv
// rs_enc_scheduler
//   Shares one symbol-serial RS(15,9) GF(16) encoder between NUM_REQ
//   requesters. A round-robin arbiter accepts one 36-bit message at a time.
//   The nine message symbols are clocked, highest first, through a 6-stage
//   parity LFSR. The result is a 60-bit systematic codeword tagged with the
//   source id. Only one codeword is in flight at any time.
//
// Ports
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   req_valid  per-requester message valid
//   req_msg    packed messages, requester r at [36r+:36], symbol i at [4i+:4]
//   req_ready  one-hot accept, asserted only in IDLE to a valid requester
//   cw_valid   codeword available (OUT state)
//   cw_data    codeword: symbols 5..0 = parity, symbols 14..6 = message
//   cw_src     index of the requester that owns cw_data
//   cw_ready   downstream accept
//   busy       encoder occupied (SHIFT or OUT)

module rs_enc_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [36*NUM_REQ-1:0]   req_msg,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    cw_valid,
    output logic [59:0]             cw_data,
    output logic [ID_W-1:0]         cw_src,
    input  logic                    cw_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr;
    logic [35:0]     msg;
    logic [3:0]      cnt;
    logic [5:0][3:0] sr, sr_nx;

    logic            any;
    logic [ID_W-1:0] gnt;
    logic [35:0]     msg_sel;
    logic [3:0]      sym, fb;
    logic [ID_W-1:0] ptr_nx;

    // Shift-and-add GF(16) multiply, x^4 + x + 1. Always called with a
    // constant second operand, so it reduces to a small XOR network.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Round-robin search starting at rr_ptr.
    always_comb begin
        int idx;
        any = 1'b0;
        gnt = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                gnt = ID_W'(idx);
            end
        end
    end

    always_comb begin
        msg_sel = '0;
        for (int r = 0; r < NUM_REQ; r++)
            if (gnt == ID_W'(r)) msg_sel = req_msg[36*r +: 36];
    end

    // Parity LFSR step; every stage reads the previous-cycle register values.
    assign sym      = msg[{cnt, 2'b00} +: 4];
    assign fb       = sr[5] ^ sym;
    assign sr_nx[0] = gf_mul(fb, 4'hC);
    assign sr_nx[1] = sr[0] ^ gf_mul(fb, 4'hA);
    assign sr_nx[2] = sr[1] ^ gf_mul(fb, 4'hC);
    assign sr_nx[3] = sr[2] ^ gf_mul(fb, 4'h3);
    assign sr_nx[4] = sr[3] ^ gf_mul(fb, 4'h9);
    assign sr_nx[5] = sr[4] ^ gf_mul(fb, 4'h7);

    assign ptr_nx = (cw_src == ID_W'(NUM_REQ - 1)) ? '0 : cw_src + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        cw_valid  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (any) state_nx = SHIFT;
                for (int r = 0; r < NUM_REQ; r++)
                    req_ready[r] = any && (gnt == ID_W'(r));
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nx = OUT;
            end
            OUT: begin
                busy     = 1'b1;
                cw_valid = 1'b1;
                if (cw_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            msg     <= '0;
            cnt     <= '0;
            sr      <= '0;
            cw_data <= '0;
            cw_src  <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    msg    <= msg_sel;
                    cw_src <= gnt;
                    sr     <= '0;
                    cnt    <= 4'd8;
                end
                SHIFT: begin
                    sr  <= sr_nx;
                    cnt <= cnt - 4'd1;
                    // Last symbol: the codeword takes the post-update parity.
                    if (cnt == 4'd0) cw_data <= {msg, sr_nx};
                end
                OUT: if (cw_ready) rr_ptr <= ptr_nx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_enc_scheduler.sv
module tb_rs_enc_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [71:0] req_msg = '0;
    logic [1:0]  req_ready;
    logic        cw_valid;
    logic [59:0] cw_data;
    logic [0:0]  cw_src;
    logic        cw_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int exp_t[15];
    int log_t[16];
    int gp[7];

    rs_enc_scheduler #(.NUM_REQ(2), .ID_W(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_msg(req_msg), .req_ready(req_ready),
        .cw_valid(cw_valid), .cw_data(cw_data), .cw_src(cw_src),
        .cw_ready(cw_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 15];
    endfunction

    // Codeword = message * x^6 plus the remainder of that mod g(x),
    // computed by plain polynomial long division.
    function automatic logic [59:0] enc_model(input logic [35:0] m);
        int c[15];
        int coef;
        logic [59:0] res;
        for (int i = 0; i < 15; i++) c[i] = 0;
        for (int i = 0; i < 9; i++) c[i+6] = int'(m[4*i +: 4]);
        for (int i = 14; i >= 6; i--) begin
            coef = c[i];
            for (int j = 0; j <= 6; j++) c[i-6+j] = c[i-6+j] ^ gmul(coef, gp[j]);
        end
        res = '0;
        res[59:24] = m;
        for (int i = 0; i < 6; i++) res[4*i +: 4] = 4'(c[i]);
        return res;
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[35:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        #2 rst = 1'b0;
    endtask

    // One isolated transaction from IDLE with cw_ready held high.
    task automatic do_one(input int r, input logic [35:0] m);
        int lat;
        @(negedge clk);
        cw_ready = 1'b1;
        req_msg = {rnd36(), rnd36()};
        req_msg[36*r +: 36] = m;
        req_valid = 2'(1 << r);
        #1 chk("grant", 64'(req_ready), 64'(1 << r));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        req_msg = {rnd36(), rnd36()};   // must not disturb the captured message
        lat = 21;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (cw_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 64'(lat), 64'd9);
        chk("cw_data", 64'(cw_data), 64'(enc_model(m)));
        chk("cw_src", 64'(cw_src), 64'(r));
        @(posedge clk);
        #1 chk("cw_drop", 64'(cw_valid), 64'd0);
    endtask

    initial begin
        logic [35:0] m0, m1, hold_msg;
        logic [59:0] snap_d;
        logic [1:0]  prev_rr;
        int exp_g, exp_src, last_rise, ncw, seen;
        logic prev_v;

        // GF(16) tables from the primitive element, x^4 + x + 1.
        begin
            int e;
            e = 1;
            for (int i = 0; i < 15; i++) begin
                exp_t[i] = e;
                log_t[e] = i;
                e = e << 1;
                if ((e & 16) != 0) e = e ^ 'h13;
            end
            log_t[0] = 0;
        end
        gp[0] = 'hC; gp[1] = 'hA; gp[2] = 'hC; gp[3] = 'h3;
        gp[4] = 'h9; gp[5] = 'h7; gp[6] = 1;

        // Reset state
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(cw_valid), 64'd0);
        chk("rst_data", 64'(cw_data), 64'd0);
        chk("rst_src", 64'(cw_src), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known vector and all-zero message
        do_one(0, 36'h0_0000_0001);
        chk("vec1_const", 64'(cw_data), 64'h000000001793CAC);
        do_one(1, 36'h0);
        chk("zero_const", 64'(cw_data), 64'd0);

        // Reset while shifting drops the message
        @(negedge clk);
        req_msg[35:0] = rnd36();
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1 chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(cw_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", 64'(cw_data), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("mid_idle", 64'(busy), 64'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1 if (cw_valid) seen = 1;
        end
        chk("mid_no_cw", 64'(seen), 64'd0);

        // Both requesters held from reset: alternating grants, 11-cycle spacing
        m0 = rnd36();
        m1 = rnd36();
        @(negedge clk);
        rst = 1'b1;
        req_msg = {m1, m0};
        req_valid = 2'b11;
        cw_ready = 1'b1;
        #2 rst = 1'b0;
        prev_rr = '0; prev_v = 1'b0;
        exp_g = 0; exp_src = 0; last_rise = -1; ncw = 0;
        for (int n = 0; n < 50; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_pulse", 64'(prev_rr), 64'd0);
                chk("rr_grant", 64'(req_ready), 64'(1 << exp_g));
                exp_g ^= 1;
            end
            if (cw_valid && !prev_v) begin
                chk("rr_src", 64'(cw_src), 64'(exp_src));
                chk("rr_data", 64'(cw_data), 64'(enc_model(exp_src == 0 ? m0 : m1)));
                if (last_rise >= 0) chk("spacing", 64'(n - last_rise), 64'd11);
                last_rise = n;
                exp_src ^= 1;
                ncw++;
            end
            prev_rr = req_ready;
            prev_v = cw_valid;
        end
        chk("rr_count", 64'(ncw >= 4), 64'd1);

        // Back-pressure in OUT
        do_reset();
        hold_msg = rnd36();
        cw_ready = 1'b0;
        req_msg[71:36] = hold_msg;
        req_valid = 2'b10;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1 if (cw_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_seen", 64'(seen), 64'd1);
        snap_d = cw_data;
        chk("bp_data", 64'(snap_d), 64'(enc_model(hold_msg)));
        req_valid = 2'b11;
        req_msg = {rnd36(), rnd36()};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 64'(cw_valid), 64'd1);
            chk("bp_hold", 64'(cw_data), 64'(snap_d));
            chk("bp_src", 64'(cw_src), 64'd1);
            chk("bp_noready", 64'(req_ready), 64'd0);
        end
        cw_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 64'(cw_valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'd1);
        req_valid = 2'b00;

        // Random messages against the model
        for (int k = 0; k < 1000; k++)
            do_one(int'($urandom_range(0, 1)), rnd36());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
